// File: rtl/periph_responder.sv
// CU peripheral bus target: TX/RX byte FIFOs, status word, latched 32-bit
// cycle counter and scratch registers, answered one cycle after the request.

module periph_responder_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2:0] rd_ptr_reg, rd_ptr_next;
  logic [WIDTH-1:0]    head_reg, head_next;
  logic                pop_ok;
  logic                push_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                   (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = head_reg;

  // The head word is prefetched from the slot the read pointer will point to;
  // a push landing in that same slot is forwarded so a fresh entry is visible.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + {{DEPTH_LOG2{1'b0}}, push_ok};
    rd_ptr_next = rd_ptr_reg + {{DEPTH_LOG2{1'b0}}, pop_ok};
    if (push_ok && (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_next[DEPTH_LOG2-1:0])) begin
      head_next = din;
    end else begin
      head_next = mem[rd_ptr_next[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      head_reg   <= head_next;
    end
  end
endmodule

module periph_responder #(
  parameter int DATA_W        = 16,
  parameter int TX_DEPTH_LOG2 = 3,
  parameter int RX_DEPTH_LOG2 = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enabled,
  input  logic [2:0]        peripheral_address,
  input  logic              peripheral_read_request,
  input  logic              peripheral_write_request,
  input  logic [DATA_W-1:0] write_data,
  output logic              peripheral_read_ready,
  output logic              peripheral_write_ready,
  output logic [DATA_W-1:0] read_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid
);
  localparam logic [2:0] ADDR_TX       = 3'd0;
  localparam logic [2:0] ADDR_RX       = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_CNT_LO   = 3'd3;
  localparam logic [2:0] ADDR_CNT_HI   = 3'd4;
  localparam logic [2:0] ADDR_SCRATCH0 = 3'd5;
  localparam int         NUM_SCRATCH   = 3;

  logic              rd_pend_reg, rd_pend_next;
  logic [2:0]        rd_addr_reg, rd_addr_next;
  logic              wr_pend_reg, wr_pend_next;
  logic [2:0]        wr_addr_reg, wr_addr_next;
  logic [31:0]       counter_reg;
  logic [15:0]       cnt_hi_reg, cnt_hi_next;
  logic              ovf_reg, ovf_next;

  logic              rd_commit, wr_commit;
  logic              rx_pop, status_clear, cnt_latch, tx_push, tx_pop;
  logic              rx_drop;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]        rx_head;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] rd_word;
  logic [NUM_SCRATCH-1:0][DATA_W-1:0] scratch_word;

  periph_responder_fifo #(
    .DEPTH_LOG2 (TX_DEPTH_LOG2),
    .WIDTH      (8)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (write_data[7:0]),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  periph_responder_fifo #(
    .DEPTH_LOG2 (RX_DEPTH_LOG2),
    .WIDTH      (8)
  ) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  // Ready flags depend only on registered state, never on this cycle's request.
  assign peripheral_read_ready  = rd_pend_reg && !((rd_addr_reg == ADDR_RX) && rx_empty);
  assign peripheral_write_ready = wr_pend_reg && !((wr_addr_reg == ADDR_TX) && tx_full);

  assign rd_commit    = enabled && peripheral_read_ready;
  assign wr_commit    = enabled && peripheral_write_ready;
  assign rx_pop       = rd_commit && (rd_addr_reg == ADDR_RX);
  assign status_clear = rd_commit && ((rd_addr_reg == ADDR_TX) || (rd_addr_reg == ADDR_STATUS));
  assign cnt_latch    = rd_commit && (rd_addr_reg == ADDR_CNT_LO);
  assign tx_push      = wr_commit && (wr_addr_reg == ADDR_TX);
  assign rx_drop      = rx_valid && rx_full && !rx_pop;

  assign status_word = DATA_W'({ovf_reg, rx_empty, tx_empty, tx_full});

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
      logic [DATA_W-1:0] value_reg;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          value_reg <= '0;
        end else if (wr_commit && (wr_addr_reg == ADDR_SCRATCH0 + 3'(gi))) begin
          value_reg <= write_data;
        end
      end
      assign scratch_word[gi] = value_reg;
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    case (rd_addr_reg)
      ADDR_TX, ADDR_STATUS: rd_word = status_word;
      ADDR_RX:              rd_word = DATA_W'(rx_head);
      ADDR_CNT_LO:          rd_word = DATA_W'(counter_reg[15:0]);
      ADDR_CNT_HI:          rd_word = DATA_W'(cnt_hi_reg);
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (rd_addr_reg == ADDR_SCRATCH0 + 3'(i)) begin
            rd_word = scratch_word[i];
          end
        end
      end
    endcase
  end

  assign read_data = peripheral_read_ready ? rd_word : '0;

  always_comb begin
    rd_pend_next = rd_pend_reg;
    rd_addr_next = rd_addr_reg;
    wr_pend_next = wr_pend_reg;
    wr_addr_next = wr_addr_reg;
    if (enabled) begin
      rd_pend_next = peripheral_read_request;
      wr_pend_next = peripheral_write_request;
      if (peripheral_read_request) begin
        rd_addr_next = peripheral_address;
      end
      if (peripheral_write_request) begin
        wr_addr_next = peripheral_address;
      end
    end
    cnt_hi_next = cnt_latch ? counter_reg[31:16] : cnt_hi_reg;
    // A drop on the clearing edge keeps the flag set.
    ovf_next    = rx_drop || (ovf_reg && !status_clear);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pend_reg <= 1'b0;
      rd_addr_reg <= '0;
      wr_pend_reg <= 1'b0;
      wr_addr_reg <= '0;
      counter_reg <= '0;
      cnt_hi_reg  <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      rd_pend_reg <= rd_pend_next;
      rd_addr_reg <= rd_addr_next;
      wr_pend_reg <= wr_pend_next;
      wr_addr_reg <= wr_addr_next;
      counter_reg <= counter_reg + 32'd1;
      cnt_hi_reg  <= cnt_hi_next;
      ovf_reg     <= ovf_next;
    end
  end
endmodule

// File: tb/tb_periph_responder.sv
// Bench for periph_responder: directed bus scenarios plus a randomized run,
// all checked against a queue-based model of the register map.

module tb_periph_responder;
  localparam int TXD = 8;
  localparam int RXD = 8;

  logic        clock;
  logic        reset;
  logic        enabled;
  logic [2:0]  peripheral_address;
  logic        peripheral_read_request;
  logic        peripheral_write_request;
  logic [15:0] write_data;
  logic        peripheral_read_ready;
  logic        peripheral_write_ready;
  logic [15:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  periph_responder #(.DATA_W(16), .TX_DEPTH_LOG2(3), .RX_DEPTH_LOG2(3)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .enabled                  (enabled),
    .peripheral_address       (peripheral_address),
    .peripheral_read_request  (peripheral_read_request),
    .peripheral_write_request (peripheral_write_request),
    .write_data               (write_data),
    .peripheral_read_ready    (peripheral_read_ready),
    .peripheral_write_ready   (peripheral_write_ready),
    .read_data                (read_data),
    .tx_data                  (tx_data),
    .tx_valid                 (tx_valid),
    .tx_ready                 (tx_ready),
    .rx_data                  (rx_data),
    .rx_valid                 (rx_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic        m_ovf;
  logic [15:0] m_scr[3];
  logic [31:0] m_cnt;
  logic [15:0] m_hi;
  logic        m_frozen;
  logic        m_rd_pend, m_wr_pend;
  logic [2:0]  m_rd_addr, m_wr_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    tx_q.delete();
    rx_q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < 3; i++) m_scr[i] = 16'h0;
    m_cnt = 32'h0;
    m_hi = 16'h0;
    m_frozen = 1'b0;
    m_rd_pend = 1'b0;
    m_wr_pend = 1'b0;
    m_rd_addr = 3'd0;
    m_wr_addr = 3'd0;
  endtask

  function automatic logic [15:0] m_status();
    return {12'h000, m_ovf, rx_q.size() == 0, tx_q.size() == 0, tx_q.size() == TXD};
  endfunction

  function automatic logic exp_rd_ready();
    return m_rd_pend && !(m_rd_addr == 3'd1 && rx_q.size() == 0);
  endfunction

  function automatic logic exp_wr_ready();
    return m_wr_pend && !(m_wr_addr == 3'd0 && tx_q.size() == TXD);
  endfunction

  function automatic logic [15:0] exp_rd_data();
    if (!exp_rd_ready()) return 16'h0;
    case (m_rd_addr)
      3'd0, 3'd2: return m_status();
      3'd1:       return {8'h00, rx_q[0]};
      3'd3:       return m_cnt[15:0];
      3'd4:       return m_hi;
      default:    return m_scr[m_rd_addr - 3'd5];
    endcase
  endfunction

  // Advance model and DUT across one rising edge using the inputs now applied.
  task automatic tick();
    logic tx_pop, rx_pop, clr, rx_full_pre;
    tx_pop = tx_ready && (tx_q.size() > 0);
    rx_pop = 1'b0;
    clr = 1'b0;
    rx_full_pre = (rx_q.size() == RXD);
    if (enabled && exp_rd_ready()) begin
      if (m_rd_addr == 3'd1) rx_pop = 1'b1;
      if (m_rd_addr == 3'd0 || m_rd_addr == 3'd2) clr = 1'b1;
      if (m_rd_addr == 3'd3) m_hi = m_cnt[31:16];
    end
    if (tx_pop) void'(tx_q.pop_front());
    if (enabled && exp_wr_ready()) begin
      if (m_wr_addr == 3'd0) tx_q.push_back(write_data[7:0]);
      else if (m_wr_addr >= 3'd5) m_scr[m_wr_addr - 3'd5] = write_data;
    end
    if (rx_pop) void'(rx_q.pop_front());
    if (clr) m_ovf = 1'b0;
    if (rx_valid) begin
      if (!rx_full_pre || rx_pop) rx_q.push_back(rx_data);
      else m_ovf = 1'b1;
    end
    if (enabled) begin
      m_rd_pend = peripheral_read_request;
      m_wr_pend = peripheral_write_request;
      if (peripheral_read_request) m_rd_addr = peripheral_address;
      if (peripheral_write_request) m_wr_addr = peripheral_address;
    end
    if (!m_frozen) m_cnt = m_cnt + 32'd1;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    @(negedge clock);
    check({tag, ".read_ready"}, peripheral_read_ready, exp_rd_ready());
    check({tag, ".read_data"}, read_data, exp_rd_data());
    check({tag, ".write_ready"}, peripheral_write_ready, exp_wr_ready());
    check({tag, ".tx_valid"}, tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) check({tag, ".tx_data"}, tx_data, tx_q[0]);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic rdy, output logic [15:0] d);
    peripheral_address = a;
    peripheral_read_request = 1'b1;
    tick();
    peripheral_read_request = 1'b0;
    @(negedge clock);
    rdy = peripheral_read_ready;
    d = read_data;
    check("read.ready_model", rdy, exp_rd_ready());
    check("read.data_model", d, exp_rd_data());
    $display("read  addr=%0d ready=%0b data=%04h", a, rdy, d);
    tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d, output logic rdy);
    peripheral_address = a;
    peripheral_write_request = 1'b1;
    tick();
    peripheral_write_request = 1'b0;
    write_data = d;
    @(negedge clock);
    rdy = peripheral_write_ready;
    check("write.ready_model", rdy, exp_wr_ready());
    $display("write addr=%0d data=%04h ready=%0b", a, d, rdy);
    tick();
  endtask

  logic        r_rdy, w_rdy;
  logic [15:0] r_d;
  logic [7:0]  ovf_bytes[9];

  initial begin
    reset = 1'b0;
    enabled = 1'b1;
    peripheral_address = 3'd0;
    peripheral_read_request = 1'b0;
    peripheral_write_request = 1'b0;
    write_data = 16'h0;
    tx_ready = 1'b0;
    rx_data = 8'h0;
    rx_valid = 1'b0;
    m_reset();

    // Reset state
    repeat (2) @(negedge clock);
    check("reset.read_ready", peripheral_read_ready, 1'b0);
    check("reset.write_ready", peripheral_write_ready, 1'b0);
    check("reset.read_data", read_data, 16'h0);
    check("reset.tx_valid", tx_valid, 1'b0);
    reset = 1'b1;
    bus_read(3'd2, r_rdy, r_d);
    check("reset.status", r_d, 16'h0006);

    // TX fill with transmitter blocked, then drain
    for (int i = 0; i < 8; i++) begin
      bus_write(3'd0, 16'h0041 + 16'(i), w_rdy);
      check("txfill.write_ready", w_rdy, 1'b1);
    end
    bus_write(3'd0, 16'h0049, w_rdy);
    check("txfull.write_ready", w_rdy, 1'b0);
    bus_read(3'd2, r_rdy, r_d);
    check("txfull.status", r_d, 16'h0005);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("txdrain.tx_valid", tx_valid, 1'b1);
      check("txdrain.tx_data", tx_data, 8'h41 + 8'(i));
      tick();
    end
    @(negedge clock);
    check("txdrain.empty", tx_valid, 1'b0);

    // RX pop on empty, then with data
    bus_read(3'd1, r_rdy, r_d);
    check("rxempty.ready", r_rdy, 1'b0);
    check("rxempty.data", r_d, 16'h0);
    rx_valid = 1'b1;
    rx_data = 8'h5A;
    tick();
    rx_valid = 1'b0;
    bus_read(3'd1, r_rdy, r_d);
    check("rxpop.ready", r_rdy, 1'b1);
    check("rxpop.data", r_d, 16'h005A);

    // RX overflow
    for (int i = 0; i < 9; i++) begin
      ovf_bytes[i] = 8'($urandom);
      rx_valid = 1'b1;
      rx_data = ovf_bytes[i];
      tick();
    end
    rx_valid = 1'b0;
    bus_read(3'd2, r_rdy, r_d);
    check("rxovf.status", r_d, 16'h000A);
    bus_read(3'd2, r_rdy, r_d);
    check("rxovf.status_cleared", r_d, 16'h0002);
    for (int i = 0; i < 8; i++) begin
      bus_read(3'd1, r_rdy, r_d);
      check("rxovf.content", r_d, {8'h00, ovf_bytes[i]});
    end
    bus_read(3'd1, r_rdy, r_d);
    check("rxovf.drained", r_rdy, 1'b0);

    // Stall on scratch read
    bus_write(3'd5, 16'h1234, w_rdy);
    peripheral_address = 3'd5;
    peripheral_read_request = 1'b1;
    tick();
    peripheral_read_request = 1'b0;
    enabled = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall.read_ready", peripheral_read_ready, 1'b1);
      check("stall.read_data", read_data, 16'h1234);
      tick();
    end
    enabled = 1'b1;
    tick();
    @(negedge clock);
    check("stall.done", peripheral_read_ready, 1'b0);

    // Stall on RX read pops exactly once
    rx_valid = 1'b1;
    rx_data = 8'h11;
    tick();
    rx_data = 8'h22;
    tick();
    rx_valid = 1'b0;
    peripheral_address = 3'd1;
    peripheral_read_request = 1'b1;
    tick();
    peripheral_read_request = 1'b0;
    enabled = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stallrx.read_data", read_data, 16'h0011);
      tick();
    end
    enabled = 1'b1;
    tick();
    bus_read(3'd1, r_rdy, r_d);
    check("stallrx.one_pop", r_d, 16'h0022);
    bus_read(3'd1, r_rdy, r_d);
    check("stallrx.empty", r_rdy, 1'b0);

    // Reset mid-operation
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(3'd0, 16'h00C0 + 16'(i), w_rdy);
    peripheral_address = 3'd5;
    peripheral_read_request = 1'b1;
    tick();
    peripheral_read_request = 1'b0;
    @(negedge clock);
    check("midrst.pending", peripheral_read_ready, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst.read_ready", peripheral_read_ready, 1'b0);
    check("midrst.read_data", read_data, 16'h0);
    check("midrst.tx_valid", tx_valid, 1'b0);
    m_reset();
    @(negedge clock);
    reset = 1'b1;
    bus_read(3'd2, r_rdy, r_d);
    check("midrst.status", r_d, 16'h0006);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      enabled = ($urandom_range(0, 4) != 0);
      peripheral_read_request = ($urandom_range(0, 2) == 0);
      peripheral_write_request = ($urandom_range(0, 2) == 0);
      peripheral_address = 3'($urandom_range(0, 7));
      write_data = 16'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data = 8'($urandom);
      check_all("rand");
      tick();
    end
    enabled = 1'b1;
    peripheral_read_request = 1'b0;
    peripheral_write_request = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (2) tick();

    // Counter low/high latch across a carry
    force dut.counter_reg = 32'h0001FFFF;
    m_cnt = 32'h0001FFFF;
    m_frozen = 1'b1;
    bus_read(3'd3, r_rdy, r_d);
    check("cnt.low", r_d, 16'hFFFF);
    force dut.counter_reg = 32'h00020005;
    m_cnt = 32'h00020005;
    repeat (2) tick();
    bus_read(3'd4, r_rdy, r_d);
    check("cnt.high_latched", r_d, 16'h0001);
    bus_read(3'd3, r_rdy, r_d);
    check("cnt.low2", r_d, 16'h0005);
    bus_read(3'd4, r_rdy, r_d);
    check("cnt.high2", r_d, 16'h0002);
    release dut.counter_reg;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
